// File: rtl/rpn_eval.sv
// Postfix expression evaluator driving an external LIFO stack.
// Keeps a shadow occupancy count so illegal pushes/pops are rejected before reaching the stack.
module rpn_eval #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tok_valid,
    output logic          tok_ready,
    input  logic          tok_is_op,
    input  logic [DW-1:0] tok_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          err,
    output logic [1:0]    err_code,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [DW-1:0] stk_din,
    input  logic [DW-1:0] stk_dout,
    input  logic          stk_full,
    input  logic          stk_empty
);

    localparam logic [AW-1:0] CNT_MAX = '1;
    localparam logic [2:0]    OP_ILL  = 3'd6;
    localparam logic [2:0]    OP_RES  = 3'd7;
    localparam logic [1:0]    E_OVF   = 2'd1;
    localparam logic [1:0]    E_UNF   = 2'd2;
    localparam logic [1:0]    E_ILL   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_POP2, S_EXEC, S_RCAP, S_ROUT} state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] b_q;
    logic [2:0]    op_q;
    logic [2:0]    opcode;
    logic          rej;
    logic [1:0]    rej_code;

    function automatic logic [DW-1:0] alu_f(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b,
                                            input logic [2:0]           op);
        logic signed [DW-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a * b;
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            3'd5:    r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        opcode    = tok_data[2:0];
        tok_ready = (state == S_IDLE);
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        rej       = 1'b0;
        rej_code  = 2'd0;
        case (state)
            S_IDLE: begin
                if (tok_valid) begin
                    if (!tok_is_op) begin
                        if (cnt != CNT_MAX && !stk_full) begin
                            stk_push = 1'b1;
                            stk_din  = tok_data;
                        end else begin
                            rej      = 1'b1;
                            rej_code = E_OVF;
                        end
                    end else if (opcode == OP_RES) begin
                        if (cnt == AW'(1)) begin
                            stk_pop = 1'b1;
                        end else begin
                            rej      = 1'b1;
                            rej_code = (cnt == '0) ? E_UNF : E_ILL;
                        end
                    end else if (opcode == OP_ILL) begin
                        rej      = 1'b1;
                        rej_code = E_ILL;
                    end else if (cnt >= AW'(2)) begin
                        stk_pop = 1'b1;
                    end else begin
                        rej      = 1'b1;
                        rej_code = E_UNF;
                    end
                end
            end
            S_POP2: stk_pop = 1'b1;
            // stk_dout holds A here; B was captured in the previous cycle
            S_EXEC: begin
                stk_push = 1'b1;
                stk_din  = alu_f(stk_dout, b_q, op_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            err <= rej;
            if (rej)
                err_code <= rej_code;
            if (stk_push)
                cnt <= cnt + AW'(1);
            else if (stk_pop)
                cnt <= cnt - AW'(1);
            case (state)
                S_IDLE: if (stk_pop) state <= (opcode == OP_RES) ? S_RCAP : S_POP2;
                S_POP2: state <= S_EXEC;
                S_EXEC: state <= S_IDLE;
                S_RCAP: begin
                    res_data  <= stk_dout;
                    res_valid <= 1'b1;
                    state     <= S_ROUT;
                end
                S_ROUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand/opcode capture is pure datapath and needs no reset
    always_ff @(posedge clk) begin
        if (state == S_IDLE && stk_pop)
            op_q <= opcode;
        if (state == S_POP2)
            b_q <= stk_dout;
    end

    a_no_push_pop : assert property (@(posedge clk) disable iff (rst) !(stk_push && stk_pop));
    a_pop_nonempty : assert property (@(posedge clk) disable iff (rst)
        stk_pop |-> (cnt != '0) && !stk_empty);

endmodule

// File: tb/tb_rpn_eval.sv
// Bench for rpn_eval: LIFO stack environment, token-level reference model and per-cycle compare.
module tb_rpn_eval;

    logic       clk, rst;
    logic       tok_valid, tok_ready, tok_is_op;
    logic [7:0] tok_data;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       err;
    logic [1:0] err_code;
    logic       stk_push, stk_pop, stk_full, stk_empty;
    logic [7:0] stk_din, stk_dout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rr_mode = 0;

    rpn_eval #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err(err), .err_code(err_code),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // LIFO stack environment (15 entries, registered read data)
    logic [7:0] mem [0:15];
    int sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp       <= 0;
            stk_dout <= '0;
        end else if (stk_push && sp < 16) begin
            mem[sp] <= stk_din;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_dout <= mem[sp-1];
            sp       <= sp - 1;
        end
    end
    assign stk_full  = (sp >= 15);
    assign stk_empty = (sp == 0);

    // Reference model: stack contents plus per-cycle expectation slots
    logic [7:0] q[$];
    bit         busy[8], epush[8], epop[8], eerr[8], rstart[8];
    logic [7:0] edin[8], rval[8];
    logic [1:0] ecval[8];
    bit         m_rv;
    logic [7:0] m_rd;
    logic [1:0] m_code;
    bit         exp_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, expv);
        end
    endtask

    function automatic int alu(input int a, input int b, input int op);
        case (op)
            0: return (a + b) & 255;
            1: return (a - b) & 255;
            2: return (a * b) & 255;
            3: return a & b;
            4: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < 8; i++) begin
            busy[i] = 0; epush[i] = 0; epop[i] = 0; eerr[i] = 0; rstart[i] = 0;
            edin[i] = '0; rval[i] = '0; ecval[i] = '0;
        end
        m_rv = 0; m_rd = '0; m_code = '0;
    endtask

    task automatic flag_err(input int c, input logic [1:0] code);
        eerr[(c+1)%8]  = 1;
        ecval[(c+1)%8] = code;
    endtask

    task automatic model_token(input bit op, input logic [7:0] d, input int c);
        int n = q.size();
        int opc = int'(d[2:0]);
        int a, b, r;
        if (!op) begin
            if (n < 15) begin
                q.push_back(d);
                epush[c%8] = 1;
                edin[c%8]  = d;
            end else flag_err(c, 2'd1);
        end else if (opc == 7) begin
            if (n == 1) begin
                rval[(c+2)%8]   = q.pop_back();
                epop[c%8]       = 1;
                busy[(c+1)%8]   = 1;
                rstart[(c+2)%8] = 1;
            end else flag_err(c, (n == 0) ? 2'd2 : 2'd3);
        end else if (opc == 6) begin
            flag_err(c, 2'd3);
        end else if (n < 2) begin
            flag_err(c, 2'd2);
        end else begin
            b = int'(q.pop_back());
            a = int'(q.pop_back());
            r = alu(a, b, opc);
            q.push_back(8'(r));
            epop[c%8]      = 1;
            epop[(c+1)%8]  = 1;
            busy[(c+1)%8]  = 1;
            busy[(c+2)%8]  = 1;
            epush[(c+2)%8] = 1;
            edin[(c+2)%8]  = 8'(r);
        end
    endtask

    always @(negedge clk) begin : compare
        int s;
        s = cyc % 8;
        if (rst) begin
            clear_model();
            chk("rst_push", 32'(stk_push), 0);
            chk("rst_pop", 32'(stk_pop), 0);
            chk("rst_din", 32'(stk_din), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_err_code", 32'(err_code), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_res_data", 32'(res_data), 0);
        end else begin
            if (eerr[s]) m_code = ecval[s];
            if (rstart[s]) begin
                m_rv = 1;
                m_rd = rval[s];
            end
            exp_ready = !(busy[s] || m_rv);
            if (tok_valid && exp_ready) model_token(tok_is_op, tok_data, cyc);
            chk("tok_ready", 32'(tok_ready), 32'(exp_ready));
            chk("stk_push", 32'(stk_push), 32'(epush[s]));
            chk("stk_pop", 32'(stk_pop), 32'(epop[s]));
            if (epush[s]) chk("stk_din", 32'(stk_din), 32'(edin[s]));
            chk("err", 32'(err), 32'(eerr[s]));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("res_valid", 32'(res_valid), 32'(m_rv));
            chk("res_data", 32'(res_data), 32'(m_rd));
            if (m_rv && res_ready) m_rv = 0;
            busy[s] = 0; epush[s] = 0; epop[s] = 0; eerr[s] = 0; rstart[s] = 0;
        end
        cyc++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode) res_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit op, input logic [7:0] d);
        int n = 0;
        tok_is_op = op;
        tok_data  = d;
        tok_valid = 1;
        forever begin
            @(negedge clk);
            if (tok_ready) break;
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL send_timeout tok_ready=%0b required=1", tok_ready);
                break;
            end
        end
        step();
        tok_valid = 0;
    endtask

    task automatic expect_result(input string nm, input logic [7:0] v, input bit hs);
        int n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (res_valid) break;
            n++;
        end
        chk({nm, "_valid"}, 32'(res_valid), 1);
        chk({nm, "_data"}, 32'(res_data), 32'(v));
        if (hs) begin
            n = 0;
            while (res_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk({nm, "_released"}, 32'(res_valid), 0);
            step();
        end
    endtask

    task automatic expect_err(input string nm, input logic [1:0] code);
        @(negedge clk);
        chk({nm, "_pulse"}, 32'(err), 1);
        chk({nm, "_code"}, 32'(err_code), 32'(code));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1; tok_valid = 0; tok_is_op = 0; tok_data = '0; res_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_tok_ready", 32'(tok_ready), 1);
        chk("reset_err_code", 32'(err_code), 0);
        chk("reset_res_valid", 32'(res_valid), 0);
        step();

        send(0, 8'd3); send(0, 8'd4); send(1, 8'd0); send(1, 8'd7);
        expect_result("add_3_4", 8'd7, 1);
        send(0, 8'd9); send(0, 8'd5); send(1, 8'd1); send(1, 8'd7);
        expect_result("sub_9_5", 8'd4, 1);
        send(0, 8'd5); send(0, 8'd9); send(1, 8'd1); send(1, 8'd7);
        expect_result("sub_wrap", 8'hFC, 1);
        send(0, 8'd16); send(0, 8'd16); send(1, 8'd2); send(1, 8'd7);
        expect_result("mul_wrap", 8'd0, 1);

        send(0, 8'd42); send(1, 8'd0);
        expect_err("underflow", 2'd2);
        send(1, 8'd7);
        expect_result("held_operand", 8'd42, 1);

        for (int i = 1; i <= 15; i++) send(0, 8'(i));
        send(0, 8'd99);
        expect_err("overflow", 2'd1);
        for (int i = 0; i < 14; i++) send(1, 8'd5);
        send(1, 8'd7);
        expect_result("xor_chain", 8'd0, 1);
        send(0, 8'd2); send(0, 8'd3); send(1, 8'd3); send(1, 8'd7);
        expect_result("and_2_3", 8'd2, 1);
        send(1, 8'd6);
        expect_err("illegal", 2'd3);

        res_ready = 0;
        send(0, 8'd7); send(1, 8'd7);
        expect_result("hold", 8'd7, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_data", 32'(res_data), 7);
            chk("hold_tok_ready", 32'(tok_ready), 0);
        end
        step();
        res_ready = 1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("release_valid", 32'(res_valid), 0);
        chk("release_tok_ready", 32'(tok_ready), 1);
        step();

        send(0, 8'd1); send(0, 8'd2); send(1, 8'd0);
        step();
        chk("exec_push", 32'(stk_push), 1);
        chk("exec_din", 32'(stk_din), 3);
        rst = 1;
        #1;
        chk("midrst_push", 32'(stk_push), 0);
        chk("midrst_tok_ready", 32'(tok_ready), 1);
        chk("midrst_res_valid", 32'(res_valid), 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("after_rst_tok_ready", 32'(tok_ready), 1);
        step();
        send(0, 8'd1); send(1, 8'd7);
        expect_result("after_rst", 8'd1, 1);

        rr_mode = 1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) step();
            r = $urandom_range(0, 99);
            if (r < 45)      send(0, 8'($urandom));
            else if (r < 55) send(1, {5'($urandom), 3'd7});
            else if (r < 58) send(1, {5'($urandom), 3'd6});
            else             send(1, {5'($urandom), 3'($urandom_range(0, 5))});
        end
        rr_mode = 0;
        res_ready = 1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
